// File: rtl/capture_pkg.sv
// Shared types and defaults for the capture controller slice.
package capture_pkg;

  localparam int unsigned CAP_ENTRIES = 384;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } cap_state_t;

endpackage

// File: rtl/mod_addr_cnt.sv
// Modulo-ENTRIES wrapping counter with synchronous clear and enable.
module mod_addr_cnt
  import capture_pkg::*;
#(
  parameter int unsigned ENTRIES = CAP_ENTRIES,
  parameter int unsigned AW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [AW-1:0] o_cnt,
  output logic [AW-1:0] o_cnt_inc
);

  localparam logic [AW-1:0] LP_LAST = AW'(ENTRIES - 1);

  logic [AW-1:0] r_cnt;

  // Depth need not be a power of two, so the wrap is explicit.
  always_comb begin
    if (r_cnt == LP_LAST) begin
      o_cnt_inc = {AW{1'b0}};
    end else begin
      o_cnt_inc = r_cnt + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {AW{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {AW{1'b0}};
    end else if (i_en) begin
      r_cnt <= o_cnt_inc;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/capture_ctrl.sv
// Sample-RAM write-side capture controller: pre-trigger fill, armed wait,
// post-trigger count and done handshake back to the trigger logic.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int unsigned ENTRIES = CAP_ENTRIES,
  parameter int unsigned AW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_run,
  input  logic          i_wrt_smpl,
  input  logic          i_triggered,
  input  logic [AW-1:0] i_trig_pos,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic          o_armed,
  output logic          o_set_capture_done,
  output logic          o_capture_done,
  output logic [AW-1:0] o_trig_addr,
  output logic [AW-1:0] o_rd_start
);

  localparam logic [AW-1:0] LP_LAST      = AW'(ENTRIES - 1);
  localparam logic [AW-1:0] LP_ENTRIES_A = AW'(ENTRIES);
  localparam logic [AW:0]   LP_ENTRIES_W = (AW+1)'(ENTRIES);

  cap_state_t    r_state, w_next_state;
  logic [AW-1:0] r_tpos, r_pre_cnt, r_post_cnt, r_trig_addr;
  logic          r_armed, r_set_capture_done, r_capture_done;
  logic          w_run_ok, w_we;
  logic [AW-1:0] w_tpos_in, w_waddr_inc, w_post_target;
  logic          w_pre_hit, w_post_last;
  logic [AW:0]   w_rd_diff, w_rd_fix;

  mod_addr_cnt #(.ENTRIES(ENTRIES), .AW(AW)) u_waddr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_run_ok),
    .i_en      (w_we),
    .o_cnt     (o_waddr),
    .o_cnt_inc (w_waddr_inc)
  );

  assign w_tpos_in     = (i_trig_pos > LP_LAST) ? LP_LAST : i_trig_pos;
  assign w_pre_hit     = ((r_pre_cnt + AW'(1)) == r_tpos);
  assign w_post_target = LP_ENTRIES_A - r_tpos - AW'(1);
  assign w_post_last   = (r_post_cnt == w_post_target);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_run) begin
          w_next_state = (w_tpos_in == {AW{1'b0}}) ? ST_ARMED : ST_FILL;
        end else begin
          w_next_state = r_state;
        end
      end
      ST_FILL:  w_next_state = (w_we && w_pre_hit) ? ST_ARMED : ST_FILL;
      ST_ARMED: w_next_state = i_triggered ? ST_POST : ST_ARMED;
      ST_POST:  w_next_state = (w_we && w_post_last) ? ST_DONE : ST_POST;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Combinational outputs: write enable and run acceptance
  always_comb begin
    w_we     = 1'b0;
    w_run_ok = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE:        w_run_ok = i_run;
      ST_FILL, ST_ARMED, ST_POST: w_we  = i_wrt_smpl;
      default: begin
        w_we     = 1'b0;
        w_run_ok = 1'b0;
      end
    endcase
  end

  // Counters, latched trigger position and trigger address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tpos      <= {AW{1'b0}};
      r_pre_cnt   <= {AW{1'b0}};
      r_post_cnt  <= {AW{1'b0}};
      r_trig_addr <= {AW{1'b0}};
    end else begin
      if (w_run_ok) begin
        r_tpos    <= w_tpos_in;
        r_pre_cnt <= {AW{1'b0}};
      end else if ((r_state == ST_FILL) && w_we) begin
        r_pre_cnt <= r_pre_cnt + AW'(1);
      end else begin
        r_pre_cnt <= r_pre_cnt;
      end
      // A write coincident with the trigger is still pre-trigger data.
      if ((r_state == ST_ARMED) && i_triggered) begin
        r_post_cnt  <= {AW{1'b0}};
        r_trig_addr <= w_we ? w_waddr_inc : o_waddr;
      end else if ((r_state == ST_POST) && w_we) begin
        r_post_cnt  <= r_post_cnt + AW'(1);
      end else begin
        r_post_cnt  <= r_post_cnt;
      end
    end
  end

  // Registered status; done pulse fires on the first cycle spent in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed            <= 1'b0;
      r_set_capture_done <= 1'b0;
      r_capture_done     <= 1'b0;
    end else begin
      r_armed            <= (w_next_state == ST_ARMED);
      r_set_capture_done <= (r_state == ST_DONE) && !r_capture_done;
      if (w_run_ok) begin
        r_capture_done <= 1'b0;
      end else if (r_state == ST_DONE) begin
        r_capture_done <= 1'b1;
      end else begin
        r_capture_done <= r_capture_done;
      end
    end
  end

  // Oldest sample address, borrow corrected back into 0..ENTRIES-1
  always_comb begin
    w_rd_diff = {1'b0, r_trig_addr} - {1'b0, r_tpos};
    if (w_rd_diff[AW]) begin
      w_rd_fix = w_rd_diff + LP_ENTRIES_W;
    end else begin
      w_rd_fix = w_rd_diff;
    end
  end

  assign o_we               = w_we;
  assign o_armed            = r_armed;
  assign o_set_capture_done = r_set_capture_done;
  assign o_capture_done     = r_capture_done;
  assign o_trig_addr        = r_trig_addr;
  assign o_rd_start         = w_rd_fix[AW-1:0];

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboarded bench for capture_ctrl with an 8-entry buffer.
module tb_capture_ctrl;

  localparam int E  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_run = 1'b0, i_wrt_smpl = 1'b0, i_triggered = 1'b0;
  logic [AW-1:0] i_trig_pos = '0;
  logic          o_we, o_armed, o_set_capture_done, o_capture_done;
  logic [AW-1:0] o_waddr, o_trig_addr, o_rd_start;

  int n_chk = 0;
  int n_err = 0;
  int n_set = 0;
  int m_addr = 0;
  int mon_a;
  int sb_q[$];

  capture_ctrl #(.ENTRIES(E), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_wrt_smpl(i_wrt_smpl),
    .i_triggered(i_triggered), .i_trig_pos(i_trig_pos), .o_we(o_we),
    .o_waddr(o_waddr), .o_armed(o_armed), .o_set_capture_done(o_set_capture_done),
    .o_capture_done(o_capture_done), .o_trig_addr(o_trig_addr), .o_rd_start(o_rd_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; an expected write pushes its address.
  task automatic step(input logic wr, input logic exp_wr);
    i_wrt_smpl = wr;
    if (exp_wr) begin
      sb_q.push_back(m_addr);
      m_addr = (m_addr + 1) % E;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int tpos);
    i_trig_pos = AW'(tpos);
    i_run = 1'b1;
    m_addr = 0;
    step(1'b0, 1'b0);
    i_run = 1'b0;
  endtask

  task automatic chk_done_seq(input int exp_sets);
    chk("set_early", o_set_capture_done, 0);
    chk("done_early", o_capture_done, 0);
    step(1'b1, 1'b0);
    chk("set_pulse", o_set_capture_done, 1);
    chk("done_set", o_capture_done, 1);
    step(1'b1, 1'b0);
    chk("set_end", o_set_capture_done, 0);
    chk("done_sticky", o_capture_done, 1);
    chk("set_count", n_set, exp_sets);
  endtask

  // Write-port monitor: pop and compare on every enabled write
  always @(negedge clk) begin
    if (o_set_capture_done) n_set++;
    if (o_we) begin
      chk("we_strobe", i_wrt_smpl, 1);
      if (sb_q.size() == 0) begin
        chk("we_unexpected", 1, 0);
      end else begin
        mon_a = sb_q.pop_front();
        chk("waddr", o_waddr, mon_a);
      end
    end else if (sb_q.size() != 0) begin
      chk("we_missing", 0, 1);
      mon_a = sb_q.pop_front();
    end
  end

  initial begin
    @(posedge clk);
    #1;
    chk("rst_waddr", o_waddr, 0);
    chk("rst_armed", o_armed, 0);
    chk("rst_done", o_capture_done, 0);
    chk("rst_set", o_set_capture_done, 0);
    chk("rst_taddr", o_trig_addr, 0);
    step(1'b1, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0);

    // Pre-trigger 3, continuous strobes
    start_run(3);
    chk("s1_waddr0", o_waddr, 0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("s1_not_armed", o_armed, 0);
    step(1'b1, 1'b1);
    chk("s1_armed", o_armed, 1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    i_triggered = 1'b1;
    i_run = 1'b1;
    step(1'b1, 1'b1);
    i_triggered = 1'b0;
    i_run = 1'b0;
    chk("s1_disarm", o_armed, 0);
    chk("s1_taddr", o_trig_addr, 6);
    chk("s1_rd_start", o_rd_start, 3);
    for (int k = 0; k < 5; k++) begin
      i_run = (k == 2);
      step(1'b1, 1'b1);
    end
    i_run = 1'b0;
    chk_done_seq(1);
    chk("s1_waddr_end", o_waddr, 3);

    // Pre-trigger 0, restarted from DONE
    start_run(0);
    chk("s2_done_clr", o_capture_done, 0);
    chk("s2_armed", o_armed, 1);
    chk("s2_waddr0", o_waddr, 0);
    step(1'b1, 1'b1);
    i_triggered = 1'b1;
    step(1'b1, 1'b1);
    i_triggered = 1'b0;
    chk("s2_taddr", o_trig_addr, 2);
    chk("s2_rd_start", o_rd_start, 2);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1);
    chk_done_seq(2);

    // Sparse strobes, trigger held high through FILL
    i_triggered = 1'b1;
    start_run(2);
    step(1'b1, 1'b1);
    chk("s3_fill_ign", o_armed, 0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    chk("s3_hold_waddr", o_waddr, 1);
    chk("s3_still_fill", o_armed, 0);
    step(1'b1, 1'b1);
    chk("s3_armed", o_armed, 1);
    step(1'b0, 1'b0);
    i_triggered = 1'b0;
    chk("s3_disarm", o_armed, 0);
    chk("s3_taddr", o_trig_addr, 2);
    chk("s3_rd_start", o_rd_start, 0);
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 3; j++) step(1'b0, 1'b0);
      step(1'b1, 1'b1);
    end
    chk_done_seq(3);

    // Reset in POST aborts everything
    start_run(1);
    step(1'b1, 1'b1);
    i_triggered = 1'b1;
    step(1'b1, 1'b1);
    i_triggered = 1'b0;
    step(1'b1, 1'b1);
    i_wrt_smpl = 1'b1;
    sb_q.push_back(m_addr);
    #2;
    sb_q.delete();
    rst_n = 1'b0;
    #1;
    chk("ar_we", o_we, 0);
    chk("ar_waddr", o_waddr, 0);
    chk("ar_armed", o_armed, 0);
    chk("ar_taddr", o_trig_addr, 0);
    chk("ar_done", o_capture_done, 0);
    chk("ar_rd_start", o_rd_start, 0);
    @(posedge clk);
    #1;
    step(1'b1, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
    chk("ar_no_pulse", n_set, 3);
    chk("ar_idle_waddr", o_waddr, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
